dice_roll_gen: RTL



---
 rtl/dice_roll_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/dice_roll_gen.sv
// Dice roll value generator: on a start pulse, re-samples a free-running LFSR
// at progressively longer intervals, then freezes on a final value.
module dice_roll_gen #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          INIT_PERIOD = 2_500_000,
    parameter int          PERIOD_STEP = 1_250_000,
    parameter int          NUM_STEPS   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic [3:0] o_random_out,
    output logic       o_show,
    output logic       o_busy,
    output logic       o_done
);

    // state | meaning
    // IDLE  | display blank, waiting for a start pulse
    // ROLL  | re-sampling the LFSR at growing intervals
    // HOLD  | final value latched and shown until the next start

    localparam int CW = $clog2(INIT_PERIOD + NUM_STEPS * PERIOD_STEP + 1);
    localparam int SW = $clog2(NUM_STEPS + 1);

    typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    out_q, out_d;
    logic          show_q, show_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [SW-1:0] step_q, step_d;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        out_d    = out_q;
        show_d   = show_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        period_d = period_q;
        step_d   = step_q;

        // A start pulse always wins, so a start mid-roll restarts from scratch.
        if (i_start) begin
            out_d    = lfsr_q[3:0];
            cnt_d    = '0;
            step_d   = '0;
            period_d = CW'(INIT_PERIOD);
            show_d   = 1'b1;
            busy_d   = 1'b1;
            state_d  = ROLL;
        end else begin
            case (state_q)
                ROLL: begin
                    if (cnt_q == period_q - CW'(1)) begin
                        cnt_d    = '0;
                        out_d    = lfsr_q[3:0];
                        step_d   = step_q + SW'(1);
                        period_d = period_q + CW'(PERIOD_STEP);
                        if (step_q == SW'(NUM_STEPS - 1)) begin
                            state_d = HOLD;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                IDLE: show_d = 1'b0;
                HOLD: show_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            out_q    <= 4'h0;
            show_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= CW'(INIT_PERIOD);
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            out_q    <= out_d;
            show_q   <= show_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            step_q   <= step_d;
        end
    end

    assign o_random_out = out_q;
    assign o_show       = show_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
